// File: rtl/fd_pipeline_register.sv
// ============================================================================
//  Module   : fd_pipeline_register
//  Brief    : Fetch/Decode pipeline register. Holds one instruction word for
//             the decode stage. Reset clears it to a NOP bubble.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fd_pipeline_register #(
    parameter int          WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] IR_Reg_IN,
    output logic [WIDTH-1:0] IR_Reg_OUT,
    input  logic             clk,
    input  logic             reset
);

    logic [WIDTH-1:0] w_ir_d;
    logic [WIDTH-1:0] r_ir_q;

    // Loads on every edge: there is no stall or flush input.
    always_comb begin
        w_ir_d = IR_Reg_IN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir_q <= RESET_VALUE;
        end else begin
            r_ir_q <= w_ir_d;
        end
    end

    assign IR_Reg_OUT = r_ir_q;

endmodule

`default_nettype wire

// File: tb/tb_fd_pipeline_register.sv
// ============================================================================
//  Module   : tb_fd_pipeline_register
//  Brief    : Self-checking bench for fd_pipeline_register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fd_pipeline_register;

    localparam int          c_width = 32;
    localparam logic [31:0] c_nop   = 32'h0000_0000;

    logic [c_width-1:0] ir_in;
    logic [c_width-1:0] ir_out;
    logic               clk;
    logic               reset;

    int compared   = 0;
    int mismatched = 0;

    // Reference: what decode should currently see.
    logic [c_width-1:0] expected;

    fd_pipeline_register #(
        .WIDTH       (c_width),
        .RESET_VALUE (c_nop)
    ) dut (
        .IR_Reg_IN  (ir_in),
        .IR_Reg_OUT (ir_out),
        .clk        (clk),
        .reset      (reset)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [c_width-1:0] exp);
        compared++;
        assert (ir_out === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, ir_out, exp);
        end
    endtask

    // Advance through one rising edge and apply the register rule to the model.
    task automatic tick();
        @(posedge clk);
        expected = reset ? ir_in : c_nop;
        #1;
    endtask

    initial begin
        logic [c_width-1:0] stream [3];
        logic               rst_bit;
        stream[0] = 32'hFFFF_FFFF;
        stream[1] = 32'h8000_0001;
        stream[2] = 32'h0000_0000;

        reset = 1'b0;
        ir_in = 32'h0000_0000;
        #10;
        check("reset_state", c_nop);
        reset = 1'b1;

        // 1: basic capture
        ir_in = 32'h0000_ABCD;
        tick();
        check("t1_capture", 32'h0000_ABCD);

        // 2: input change mid-cycle must not leak through
        #20;
        ir_in = 32'h0000_1234;
        #5;
        check("t2_stable", 32'h0000_ABCD);
        tick();
        check("t2_capture", 32'h0000_1234);

        // 3: asynchronous reset between edges, then held through an edge
        #20;
        reset = 1'b0;
        #1;
        check("t3_async", c_nop);
        tick();
        check("t3_hold", c_nop);

        // 4: no dead cycle after release
        #20;
        reset = 1'b1;
        ir_in = 32'h0000_1598;
        #5;
        check("t4_pre_edge", c_nop);
        tick();
        check("t4_release", 32'h0000_1598);

        // 5: back-to-back stream
        for (int i = 0; i < 3; i++) begin
            ir_in = stream[i];
            #20;
            check("t5_pre_edge", expected);
            tick();
            check("t5_stream", stream[i]);
        end

        // 6: reset held while input toggles
        #10;
        reset = 1'b0;
        #1;
        check("t6_assert", c_nop);
        for (int i = 0; i < 5; i++) begin
            ir_in = (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h1357_9BDF;
            tick();
            check("t6_hold", c_nop);
        end
        #20;
        reset = 1'b1;

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 300; i++) begin
            rst_bit = ($urandom_range(0, 7) != 0);
            #10;
            ir_in = $urandom;
            if (!rst_bit && reset) begin
                reset = 1'b0;
                expected = c_nop;
                #1;
                check("rnd_async", expected);
            end else begin
                reset = rst_bit;
                #1;
            end
            #20;
            ir_in = $urandom;
            #1;
            check("rnd_stable", expected);
            tick();
            check("rnd_edge", expected);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
